if_id_skid_reg: RTL
===================

# if_id_skid_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, a two-entry skid buffer, synchronous flush-to-bubble and a saturating back-pressure counter. It sits between instruction fetch and decode. Two properties matter: fetch's ready input is a registered signal, so no combinational path runs from decode back to fetch, and a decode stall never drops or duplicates an instruction.

## Interface
- `INST_W`, default 32: instruction width.
- `ADDR_W`, default 64: instruction address width.
- `NOP_INST`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- `SKID`, default 1: 1 gives the two-entry skid with registered `in_ready`; 0 gives a single entry with combinational `in_ready`.
- `CNT_W`, default 16: stall counter width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: discard all held and incoming entries.
- `in_valid`  in  1: fetch presents an entry.
- `in_ready`  out  1: stage can accept an entry.
- `in_inst`  in  `INST_W`: fetched instruction.
- `in_addr`  in  `ADDR_W`: address of the instruction.
- `out_valid`  out  1: decode-side entry valid.
- `out_ready`  in  1: decode consumes the entry.
- `out_inst`  out  `INST_W`: instruction to decode.
- `out_addr`  out  `ADDR_W`: address to decode.
- `stall_cnt`  out  `CNT_W`: cycles with `out_valid && !out_ready`.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- Storage:
  - main entry (`m_valid`, `m_inst`, `m_addr`) drives the outputs;
  - skid entry (`s_valid`, `s_inst`, `s_addr`) exists only when `SKID=1`.
- States when `SKID=1`:
  - EMPTY = !m_valid.
  - ONE = m_valid && !s_valid.
  - TWO = m_valid && s_valid.
- Transitions, when no reset and no flush:
  - EMPTY + push -> ONE, main loads the input.
  - ONE + push + pop -> ONE, main loads the input.
  - ONE + push + no pop -> TWO, skid loads the input.
  - ONE + pop + no push -> EMPTY.
  - TWO + pop -> ONE, main loads the skid entry; no push is possible because `in_ready`=0.
  - Any other combination holds the state.
- Order is strictly FIFO: the skid entry is always younger than the main entry.
- `in_ready` when `SKID=1`: registered; equals !s_valid after the update. It is 1 in EMPTY and ONE, 0 in TWO.
- `in_ready` when `SKID=0`: `!m_valid || out_ready`, combinational. No TWO state exists.
- Outputs:
  - `out_valid` = m_valid.
  - While m_valid=0: `out_inst`=`NOP_INST`, `out_addr`=0.
- Flush:
  - Priority is reset > flush > push/pop.
  - Next state is EMPTY, with `s_valid`=0 and `in_ready`=1.
  - An entry pushed in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed by decode.
- `stall_cnt`:
  - increments on every cycle with `out_valid && !out_ready`;
  - saturates at 2^`CNT_W`-1;
  - is cleared only by reset, not by flush.

## Timing
- Latency: an entry pushed at edge N is visible on `out_*` after edge N, i.e. 1 cycle. Throughput is 1 entry/cycle when `out_ready`=1.
- `SKID=1`: `in_ready` falls the cycle after the stall begins. The skid absorbs the one in-flight entry.
- Reset values:
  - `out_valid`=0, `out_inst`=`NOP_INST`, `out_addr`=0;
  - `in_ready`=1 for `SKID=1`, `in_ready`=!m_valid||out_ready=1 for `SKID=0`;
  - `stall_cnt`=0; state EMPTY.
- Reset asserted mid-operation discards both entries on that edge. Any push in that cycle is ignored.
- Flush and reset are both sampled only at `clk` rising edges. A one-cycle pulse is sufficient.

## Structure
- Shared package `pipe_pkg` holds:
  - `NOP_INST_RV` constant (32'h0000_0013);
  - `skid_state_e` enum (`EMPTY`, `ONE`, `TWO`).
  
  Other pipeline registers (ID/EX, EX/MEM) will reuse both.
- One sub-module: `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `count`). It implements `stall_cnt` and will be reused for other performance counters.
- All state updates sit in a single clocked process. The output mux stays combinational from the main entry.

## Test plan
- Reset then idle:
  - expect `out_valid`=0, `out_inst`=32'h0000_0013, `out_addr`=0, `in_ready`=1, `stall_cnt`=0.
- Streaming, `out_ready`=1:
  - push A=(32'h00500093, 64'h0), B=(32'h00A00113, 64'h4) on consecutive cycles;
  - expect A out 1 cycle after its push, then B; no gaps.
- Stall with skid, `SKID=1`:
  - hold `out_ready`=0 and push A, B, C;
  - expect A held on the outputs, B in skid, `in_ready`=0 after B, C not accepted;
  - release `out_ready`; expect A, B, C in order, with `stall_cnt` equal to the stall cycle count.
- Flush in TWO with a concurrent push:
  - expect `out_valid`=0 and `out_inst`=NOP next cycle, `in_ready`=1, the pushed entry absent;
  - `stall_cnt` keeps its value.
- Counter saturation:
  - with `CNT_W`=3, stall 10 cycles; expect `stall_cnt`=7.
- `SKID=0` build:
  - `in_ready` follows `out_ready` combinationally while full;
  - stream and stall sequences give the same ordering as `SKID=1`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: bubble encoding and skid occupancy states.
package pipe_pkg;

  // addi x0,x0,0 -- the canonical RISC-V bubble.
  localparam logic [31:0] NOP_INST_RV = 32'h0000_0013;

  // Occupancy of a main+skid pipeline register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment on event unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: valid/ready handshake, optional two-entry skid so
// that fetch's ready is a flop, synchronous flush to bubble, stall counter.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 64,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_RV),
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state_q, state_d;
  logic [INST_W-1:0] m_inst_q, m_inst_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [INST_W-1:0] s_inst_q, s_inst_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic              in_ready_q, in_ready_d;

  logic m_valid;
  logic push;
  logic pop;

  assign m_valid = (state_q != EMPTY);

  // With the skid, ready comes straight from a flop; without it, ready must
  // look at decode's ready to keep full throughput from a single entry.
  assign in_ready = (SKID != 0) ? in_ready_q : (!m_valid || out_ready);

  assign push = in_valid && in_ready;
  assign pop  = m_valid && out_ready;

  // Next-state: FIFO-ordered main/skid occupancy, flush overrides handshakes.
  always_comb begin
    state_d  = state_q;
    m_inst_d = m_inst_q;
    m_addr_d = m_addr_q;
    s_inst_d = s_inst_q;
    s_addr_d = s_addr_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d  = ONE;
          m_inst_d = in_inst;
          m_addr_d = in_addr;
        end
      end
      ONE: begin
        if (push && pop) begin
          m_inst_d = in_inst;
          m_addr_d = in_addr;
        end else if (push) begin
          // Only reachable with the skid: without it, ready implies pop here.
          state_d  = TWO;
          s_inst_d = in_inst;
          s_addr_d = in_addr;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Ready is low in TWO, so a pop simply promotes the younger entry.
        if (pop) begin
          state_d  = ONE;
          m_inst_d = s_inst_q;
          m_addr_d = s_addr_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    in_ready_d = (state_d != TWO);
  end

  // All storage updates; reset beats everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_inst_q   <= NOP_INST;
      m_addr_q   <= '0;
      s_inst_q   <= NOP_INST;
      s_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_inst_q   <= m_inst_d;
      m_addr_q   <= m_addr_d;
      s_inst_q   <= s_inst_d;
      s_addr_q   <= s_addr_d;
    end
  end

  // Decode sees the main entry, or a clean bubble when nothing is held.
  assign out_valid = m_valid;
  assign out_inst  = m_valid ? m_inst_q : NOP_INST;
  assign out_addr  = m_valid ? m_addr_q : '0;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (m_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule
